// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: instruction field positions, fetch FSM states, default reset PC.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mips_pkg;

    // Instruction field bit positions
    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    // Fetch FSM: S_DROP means a stale request to the pre-redirect PC is still outstanding
    typedef enum logic {
        S_FETCH = 1'b0,
        S_DROP  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction-memory req/ack port between the fetch unit (master) and memory (slave).
// Latency: a transfer completes at the edge where req and ack are both high.
// Backpressure: memory holds ack low to stall; master keeps addr stable while req is high and ack low.
interface if_id_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_skid_buf.sv
// One-entry {inst, pc4} holding register for a word fetched while ID is stalled.
// Latency: 1 cycle from load to valid; unload/clear take effect at the next edge.
// Backpressure: owner must not load while valid (fetch request is low while full).
module if_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc4,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc4
);

    // Entry register: reset and clear dominate, then load, then unload
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            inst  <= '0;
            pc4   <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= in_inst;
            pc4   <= in_pc4;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// MIPS fetch unit + IF/ID register: owns PC, drives imem req/ack, slices the captured word into decode fields.
// Latency: fetched word visible in ID the cycle after its ack; fields are slices of the ID register.
// Backpressure: stall holds ID, one extra word parks in the skid buffer and req drops until it drains.
// Optional build macro IF_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module if_id_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    if_id_stage_if.master        imem,
    output logic                 id_valid,
    output logic [31:0]          id_pc4,
    output logic [31:0]          id_inst,
    output logic [5:0]           id_opcode,
    output logic [4:0]           id_rs,
    output logic [4:0]           id_rt,
    output logic [4:0]           id_rd,
    output logic [5:0]           id_funct,
    output logic [15:0]          id_imm_16
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    fetch_state_t state;
    logic [31:0]  pc, drop_addr, pc_plus4;
    logic [31:0]  pc_nxt, drop_nxt;
    fetch_state_t state_nxt;
    logic         buf_valid;
    logic [31:0]  buf_inst, buf_pc4;
    logic         fetch_ok;
    logic         id_kill, id_load_mem, id_load_buf;
    logic         buf_load, buf_unload, buf_clear;

    assign pc_plus4        = pc + 32'd4;
    assign imem.imem_req   = !rst && !buf_valid;
    assign imem.imem_addr  = (state == S_DROP) ? drop_addr : pc;
    assign fetch_ok        = imem.imem_req && imem.imem_ack;

    // Next-state decode; priority redirect > flush > stall (reset handled in the registers)
    always_comb begin
        pc_nxt      = pc;
        drop_nxt    = drop_addr;
        state_nxt   = state;
        id_kill     = 1'b0;
        id_load_mem = 1'b0;
        id_load_buf = 1'b0;
        buf_load    = 1'b0;
        buf_unload  = 1'b0;
        buf_clear   = 1'b0;
        if (redirect_valid) begin
            pc_nxt    = redirect_pc;
            id_kill   = 1'b1;
            buf_clear = 1'b1;
            if (state == S_FETCH && imem.imem_req && !imem.imem_ack) begin
                // Old request still in flight: remember its address and eat its data later
                drop_nxt  = pc;
                state_nxt = S_DROP;
            end else if (state == S_DROP && imem.imem_ack) begin
                state_nxt = S_FETCH;
            end
        end else if (state == S_DROP) begin
            if (imem.imem_ack) state_nxt = S_FETCH;
            if (flush) begin
                id_kill   = 1'b1;
                buf_clear = 1'b1;
            end
        end else if (flush) begin
            id_kill   = 1'b1;
            buf_clear = 1'b1;
            if (fetch_ok) pc_nxt = pc_plus4;
        end else if (fetch_ok) begin
            pc_nxt = pc_plus4;
            if (!stall || !id_valid) id_load_mem = 1'b1;
            else                     buf_load    = 1'b1;
        end else if (!stall) begin
            if (buf_valid) begin
                id_load_buf = 1'b1;
                buf_unload  = 1'b1;
            end else begin
                id_kill = 1'b1;
            end
        end
    end

    // PC, FSM state and stale-request address
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            drop_addr <= '0;
            state     <= S_FETCH;
        end else begin
            pc        <= pc_nxt;
            drop_addr <= drop_nxt;
            state     <= state_nxt;
        end
    end

    // IF/ID pipeline register; holds when nothing loads or kills it (stall)
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_inst  <= '0;
            id_pc4   <= '0;
        end else if (id_kill) begin
            id_valid <= 1'b0;
        end else if (id_load_mem) begin
            id_valid <= 1'b1;
            id_inst  <= imem.imem_rdata;
            id_pc4   <= pc_plus4;
        end else if (id_load_buf) begin
            id_valid <= 1'b1;
            id_inst  <= buf_inst;
            id_pc4   <= buf_pc4;
        end
    end

    if_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (buf_load),
        .unload  (buf_unload),
        .clear   (buf_clear),
        .in_inst (imem.imem_rdata),
        .in_pc4  (pc_plus4),
        .valid   (buf_valid),
        .inst    (buf_inst),
        .pc4     (buf_pc4)
    );

    assign id_opcode = id_inst[OPC_HI:OPC_LO];
    assign id_rs     = id_inst[RS_HI:RS_LO];
    assign id_rt     = id_inst[RT_HI:RT_LO];
    assign id_rd     = id_inst[RD_HI:RD_LO];
    assign id_funct  = id_inst[FUNCT_HI:FUNCT_LO];
    assign id_imm_16 = id_inst[IMM_HI:IMM_LO];

`ifdef IF_PERF_CNT_EN
    // Performance counters: delivered fetches and stalled-with-live-instruction cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (id_load_mem || buf_load) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall && id_valid)       perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
